// File: rtl/rpn_operand_stack_pkg.sv
// Shared types and constants for the RPN operand stack.
// Opcodes, widths and the controller state encoding.
package rpn_operand_stack_pkg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    localparam logic [3:0] FULL = 4'd8;

    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_NOT   = 3'b111;
    localparam logic [2:0] UNARY_OP = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Operands consumed by an opcode: NOT takes one, all others two.
    function automatic logic [3:0] need_of(logic [2:0] op);
        return (op == UNARY_OP) ? 4'd1 : 4'd2;
    endfunction

endpackage

// File: rtl/rpn_operand_stack_if.sv
// Operand/result bus between the stack and the ALU.
// master = stack side, slave = ALU side.
interface rpn_operand_stack_if;
    import rpn_operand_stack_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             alu_valid;
    logic [WIDTH-1:0] r;
    logic             r_valid;

    modport master (
        output a, b, sel, alu_valid,
        input  r, r_valid
    );

    modport slave (
        input  a, b, sel, alu_valid,
        output r, r_valid
    );

endinterface

// File: rtl/rpn_operand_stack_decoder.sv
// 3-to-8 one-hot write strobe decoder.
// Each strobe enables one stack entry register.
module decoder_3to8 (
    input  logic       en,
    input  logic [2:0] ptr,
    output logic [7:0] stb
);

    // One strobe high for the addressed entry when enabled.
    always_comb begin
        stb = '0;
        if (en) begin
            stb[ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/rpn_operand_stack.sv
// Eight-entry operand stack feeding the RPN ALU.
// Pops operands for an op and pushes the result back.
module rpn_operand_stack
    import rpn_operand_stack_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 op_req,
    input  logic [2:0]           opsel,
    rpn_operand_stack_if.master  alu,
    output logic [WIDTH-1:0]     top,
    output logic [3:0]           count,
    output logic                 busy,
    output logic                 done,
    output logic                 err_under,
    output logic                 err_over
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [2:0]       sel_q;
    logic             ld_ops;
    logic             done_q;
    logic             done_d;
    logic             under_q;
    logic             under_d;
    logic             over_q;
    logic             over_d;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [DEPTH-1:0] wr_stb;
    logic [2:0]       ptr_top;
    logic [2:0]       ptr_nxt;

    // Wraps correctly at COUNT=8 since only the low bits index.
    assign ptr_top = cnt_q[2:0] - 3'd1;
    assign ptr_nxt = cnt_q[2:0] - 3'd2;

    // Next-state, write request and operand fetch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_data = din;
        ld_ops  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
        under_d = 1'b0;
        over_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_req) begin
                    if (cnt_q < need_of(opsel)) begin
                        under_d = 1'b1;
                    end else begin
                        ld_ops  = 1'b1;
                        state_d = EXEC;
                        if (opsel == UNARY_OP) begin
                            a_d   = stk_q[ptr_top];
                            b_d   = '0;
                            cnt_d = cnt_q - 4'd1;
                        end else begin
                            a_d   = stk_q[ptr_nxt];
                            b_d   = stk_q[ptr_top];
                            cnt_d = cnt_q - 4'd2;
                        end
                    end
                end else if (push) begin
                    if (cnt_q == FULL) begin
                        over_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            EXEC: begin
                if (alu.r_valid) begin
                    wr_en   = 1'b1;
                    wr_data = alu.r;
                    cnt_d   = cnt_q + 4'd1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    decoder_3to8 u_dec (
        .en  (wr_en),
        .ptr (cnt_q[2:0]),
        .stb (wr_stb)
    );

    // Stack entries, each written only by its own strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_stb[i]) begin
                    stk_q[i] <= wr_data;
                end
            end
        end
    end

    // Controller state, count, ALU operands and pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            under_q <= under_d;
            over_q  <= over_d;
            if (ld_ops) begin
                a_q   <= a_d;
                b_q   <= b_d;
                sel_q <= opsel;
            end
        end
    end

    assign alu.a         = a_q;
    assign alu.b         = b_q;
    assign alu.sel       = sel_q;
    assign alu.alu_valid = (state_q == EXEC);

    assign top       = (cnt_q == 4'd0) ? '0 : stk_q[ptr_top];
    assign count     = cnt_q;
    assign busy      = (state_q == EXEC);
    assign done      = done_q;
    assign err_under = under_q;
    assign err_over  = over_q;

endmodule

// File: tb/tb_rpn_operand_stack.sv
// Bench for rpn_operand_stack: vector table, corner
// sequences, then random traffic against a queue model.
module tb_rpn_operand_stack;
    import rpn_operand_stack_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push;
    logic [7:0] din;
    logic       op_req;
    logic [2:0] opsel;
    logic [7:0] top;
    logic [3:0] count;
    logic       busy, done, err_under, err_over;

    rpn_operand_stack_if bus ();

    rpn_operand_stack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .din       (din),
        .op_req    (op_req),
        .opsel     (opsel),
        .alu       (bus),
        .top       (top),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err_under (err_under),
        .err_over  (err_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic       push;
        logic [7:0] din;
        logic       op_req;
        logic [2:0] opsel;
        logic       rv;
        logic [7:0] r;
        logic [3:0] cnt;
        logic [7:0] top;
        logic       busy;
        logic       done;
        logic       und;
        logic       ovr;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        logic rs, logic p, logic [7:0] d, logic o, logic [2:0] os,
        logic rv, logic [7:0] r, logic [3:0] c, logic [7:0] t,
        logic bz, logic dn, logic un, logic ov,
        logic [7:0] a, logic [7:0] b, logic [2:0] s);
        vec_t v;
        v.rst_n = rs; v.push = p; v.din = d; v.op_req = o;
        v.opsel = os; v.rv = rv; v.r = r; v.cnt = c; v.top = t;
        v.busy = bz; v.done = dn; v.und = un; v.ovr = ov;
        v.a = a; v.b = b; v.sel = s;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic rs, logic p, logic [7:0] d, logic o,
                         logic [2:0] os, logic rv, logic [7:0] r);
        rst_n = rs; push = p; din = d; op_req = o; opsel = os;
        bus.r_valid = rv; bus.r = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: stack as a queue, ALU bus as plain regs.
    logic [7:0] mq[$];
    logic       m_busy, m_done, m_und, m_ovr;
    logic [7:0] m_a, m_b;
    logic [2:0] m_sel;

    function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b,
                                          logic [2:0] s);
        case (s)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOT:  return ~a;
            default: return a + b;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_done = 0; m_und = 0; m_ovr = 0;
        m_a = 0; m_b = 0; m_sel = 0;
    endtask

    task automatic model_step();
        int need;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_done = 0; m_und = 0; m_ovr = 0;
        if (!m_busy) begin
            if (op_req) begin
                need = (opsel == 3'b111) ? 1 : 2;
                if (mq.size() < need) begin
                    m_und = 1;
                end else begin
                    if (need == 1) begin
                        m_a = mq.pop_back();
                        m_b = 0;
                    end else begin
                        m_b = mq.pop_back();
                        m_a = mq.pop_back();
                    end
                    m_sel  = opsel;
                    m_busy = 1;
                end
            end else if (push) begin
                if (mq.size() == 8) m_ovr = 1;
                else mq.push_back(din);
            end
        end else if (bus.r_valid) begin
            mq.push_back(bus.r);
            m_done = 1;
            m_busy = 0;
        end
    endtask

    task automatic check_model();
        chk("r_count", 32'(count), 32'(mq.size()));
        chk("r_top", 32'(top), mq.size() ? 32'(mq[$]) : 32'd0);
        chk("r_busy", 32'(busy), 32'(m_busy));
        chk("r_alu_valid", 32'(bus.alu_valid), 32'(m_busy));
        chk("r_done", 32'(done), 32'(m_done));
        chk("r_under", 32'(err_under), 32'(m_und));
        chk("r_over", 32'(err_over), 32'(m_ovr));
        chk("r_a", 32'(bus.a), 32'(m_a));
        chk("r_b", 32'(bus.b), 32'(m_b));
        chk("r_sel", 32'(bus.sel), 32'(m_sel));
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);

        // reset, AND, NOT, XOR, underflow
        tv.push_back(mk(0,0,8'h00,0,3'd0,0,8'h00, 0,8'h00,0,0,0,0,8'h00,8'h00,3'd0));
        tv.push_back(mk(1,1,8'h05,0,3'd0,0,8'h00, 1,8'h05,0,0,0,0,8'h00,8'h00,3'd0));
        tv.push_back(mk(1,1,8'h03,0,3'd0,0,8'h00, 2,8'h03,0,0,0,0,8'h00,8'h00,3'd0));
        tv.push_back(mk(1,0,8'h00,1,3'd4,0,8'h00, 0,8'h00,1,0,0,0,8'h05,8'h03,3'd4));
        tv.push_back(mk(1,0,8'h00,0,3'd0,1,8'h01, 1,8'h01,0,1,0,0,8'h05,8'h03,3'd4));
        tv.push_back(mk(1,1,8'h0F,0,3'd0,0,8'h00, 2,8'h0F,0,0,0,0,8'h05,8'h03,3'd4));
        tv.push_back(mk(1,0,8'h00,1,3'd7,0,8'h00, 1,8'h01,1,0,0,0,8'h0F,8'h00,3'd7));
        tv.push_back(mk(1,0,8'h00,0,3'd0,1,8'hF0, 2,8'hF0,0,1,0,0,8'h0F,8'h00,3'd7));
        tv.push_back(mk(1,0,8'h00,1,3'd6,0,8'h00, 0,8'h00,1,0,0,0,8'h01,8'hF0,3'd6));
        tv.push_back(mk(1,0,8'h00,0,3'd0,1,8'hF1, 1,8'hF1,0,1,0,0,8'h01,8'hF0,3'd6));
        tv.push_back(mk(1,0,8'h00,1,3'd5,0,8'h00, 1,8'hF1,0,0,1,0,8'h01,8'hF0,3'd6));
        tv.push_back(mk(1,0,8'h00,0,3'd0,0,8'h00, 1,8'hF1,0,0,0,0,8'h01,8'hF0,3'd6));
        // reset, then nine pushes: the ninth overflows
        tv.push_back(mk(0,0,8'h00,0,3'd0,0,8'h00, 0,8'h00,0,0,0,0,8'h00,8'h00,3'd0));
        for (int k = 1; k <= 8; k++)
            tv.push_back(mk(1,1,8'(k),0,3'd0,0,8'h00, 4'(k),8'(k),0,0,0,0,
                            8'h00,8'h00,3'd0));
        tv.push_back(mk(1,1,8'h09,0,3'd0,0,8'h00, 8,8'h08,0,0,0,1,8'h00,8'h00,3'd0));
        tv.push_back(mk(1,0,8'h00,0,3'd0,0,8'h00, 8,8'h08,0,0,0,0,8'h00,8'h00,3'd0));
        // push and op together: op wins, push dropped
        tv.push_back(mk(1,1,8'hAA,1,3'd4,0,8'h00, 6,8'h06,1,0,0,0,8'h07,8'h08,3'd4));
        tv.push_back(mk(1,0,8'h00,0,3'd0,1,8'h00, 7,8'h00,0,1,0,0,8'h07,8'h08,3'd4));

        foreach (tv[i]) begin
            drive(tv[i].rst_n, tv[i].push, tv[i].din, tv[i].op_req,
                  tv[i].opsel, tv[i].rv, tv[i].r);
            cyc();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].cnt));
            chk($sformatf("v%0d_top", i), 32'(top), 32'(tv[i].top));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].busy));
            chk($sformatf("v%0d_aluv", i), 32'(bus.alu_valid), 32'(tv[i].busy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tv[i].done));
            chk($sformatf("v%0d_under", i), 32'(err_under), 32'(tv[i].und));
            chk($sformatf("v%0d_over", i), 32'(err_over), 32'(tv[i].ovr));
            chk($sformatf("v%0d_a", i), 32'(bus.a), 32'(tv[i].a));
            chk($sformatf("v%0d_b", i), 32'(bus.b), 32'(tv[i].b));
            chk($sformatf("v%0d_sel", i), 32'(bus.sel), 32'(tv[i].sel));
        end

        // delayed result, pushes during EXEC are ignored
        drive(0, 0, 0, 0, 0, 0, 0); cyc();
        drive(1, 1, 8'h3C, 0, 0, 0, 0); cyc();
        drive(1, 1, 8'h35, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 1, OP_AND, 0, 0); cyc();
        chk("dly_busy0", 32'(busy), 32'd1);
        chk("dly_a", 32'(bus.a), 32'h3C);
        chk("dly_b", 32'(bus.b), 32'h35);
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 8'hAA, 0, 0, 0, 8'hAA); cyc();
            chk($sformatf("dly_busy%0d", k + 1), 32'(busy), 32'd1);
            chk($sformatf("dly_done%0d", k + 1), 32'(done), 32'd0);
            chk($sformatf("dly_cnt%0d", k + 1), 32'(count), 32'd0);
            chk($sformatf("dly_over%0d", k + 1), 32'(err_over), 32'd0);
        end
        drive(1, 1, 8'hAA, 0, 0, 1, 8'h34); cyc();
        chk("dly_done", 32'(done), 32'd1);
        chk("dly_busy3", 32'(busy), 32'd0);
        chk("dly_cnt", 32'(count), 32'd1);
        chk("dly_top", 32'(top), 32'h34);
        drive(1, 0, 0, 0, 0, 0, 0); cyc();
        chk("dly_done_end", 32'(done), 32'd0);
        chk("dly_cnt_end", 32'(count), 32'd1);
        chk("dly_top_end", 32'(top), 32'h34);

        // reset while EXEC aborts the op
        drive(1, 1, 8'h77, 0, 0, 0, 0); cyc();
        drive(1, 1, 8'h66, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 1, OP_OR, 0, 0); cyc();
        chk("rx_busy", 32'(busy), 32'd1);
        chk("rx_cnt", 32'(count), 32'd1);
        drive(0, 0, 0, 0, 0, 1, 8'h77); cyc();
        chk("rx_cnt0", 32'(count), 32'd0);
        chk("rx_top0", 32'(top), 32'd0);
        chk("rx_busy0", 32'(busy), 32'd0);
        chk("rx_aluv0", 32'(bus.alu_valid), 32'd0);
        chk("rx_done0", 32'(done), 32'd0);
        chk("rx_a0", 32'(bus.a), 32'd0);
        chk("rx_b0", 32'(bus.b), 32'd0);
        chk("rx_sel0", 32'(bus.sel), 32'd0);
        drive(1, 0, 0, 0, 0, 1, 8'h77); cyc();
        chk("rx_done1", 32'(done), 32'd0);
        chk("rx_cnt1", 32'(count), 32'd0);

        // random traffic against the queue model
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        model_step();
        cyc();
        check_model();
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            push        = ($urandom_range(0, 99) < 45);
            din         = 8'($urandom);
            op_req      = ($urandom_range(0, 99) < 30);
            opsel       = 3'($urandom);
            bus.r_valid = ($urandom_range(0, 1) == 1);
            bus.r       = alu_fn(m_a, m_b, m_sel);
            model_step();
            cyc();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
